ysyx_040066_clint: RTL and testbench
====================================

YSYX_040066_CLINT -- requirements
Module: ysyx_040066_clint

Interface
REQ-001 Parameter TICK_DIV, default 1, clk cycles per mtime increment (legal range 1..65535).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset: synchronous, active-low.
REQ-004 req_valid  input  1  bus request present.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 req_wen  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  16  byte offset from the CLINT base.
REQ-008 req_wdata  input  64  write data.
REQ-009 req_wmask  input  8  byte enables for writes; bit i covers bits [8i+7:8i].
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  response consumed when resp_valid && resp_ready.
REQ-012 resp_rdata  output  64  read data; 0 for writes and errors.
REQ-013 resp_err  output  1  unmapped or misaligned access.
REQ-014 mstatus  input  64  core mstatus; only bit 3 (MIE) is used.
REQ-015 mie  input  64  core mie; only bits 3 (MSIE) and 7 (MTIE) are used.
REQ-016 irq  output  1  interrupt request to the core trap logic.
REQ-017 irq_no  output  64  cause code for irq (the core's NO input).
REQ-018 irq_ack  input  1  core took the trap this cycle.
REQ-019 mtip, msip  output  1 each  raw pending bits, for the core's mip.

Function
REQ-020 Register map: msip at 0x0000 (bit 0 only, other bits read 0), mtimecmp at 0x4000, mtime at 0xBFF8, each 64 bits.
REQ-021 Access rules: req_addr[2:0] != 0 or any other address -> resp_err=1, resp_rdata=0, no state change.
REQ-022 req_ready = !resp_valid, giving one outstanding transaction.
REQ-023 Response timing: resp_valid rises the cycle after acceptance and holds with stable rdata/err until resp_ready is sampled high.
REQ-024 Read data is the register value before the accepting edge.
REQ-025 Writes take effect at the accepting edge, honouring req_wmask per byte.
REQ-026 Prescaler: counts 0..TICK_DIV-1 and wraps; mtime increments by 1 on wrap; mtime wraps 2^64-1 -> 0.
REQ-027 An mtime write in the same cycle as an increment wins (written bytes take the write value, unwritten bytes take the incremented value), and the prescaler resets to 0.
REQ-028 mtip = (mtime >= mtimecmp), unsigned and combinational from the registers; msip output = msip register bit 0.
REQ-029 Interrupt condition: en_s = MIE && MSIE && msip; en_t = MIE && MTIE && mtip; code = 0x8000_0000_0000_0003 if en_s, else 0x8000_0000_0000_0007 (software beats timer).
REQ-030 FSM IDLE: if en_s||en_t, latch code into irq_no and go to REQ.
REQ-031 FSM REQ: irq=1 and irq_no stays stable. irq_ack -> ACKED. No ack and the condition drops -> IDLE (request withdrawn).
REQ-032 FSM ACKED: irq=0 for exactly one cycle, then IDLE. irq_ack outside REQ is ignored.
REQ-033 irq is a registered output: irq=1 iff state==REQ.

Reset
REQ-034 While rst=0 at an edge, the following reset values are loaded: mtime=0, mtimecmp=all ones, msip=0, prescaler=0, state=IDLE, irq=0, irq_no=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-035 Reset mid-transaction or mid-REQ drops the pending response and request, with no residual effect after release.

Structure
REQ-036 A shared package holds the register offsets, the cause codes (0x...03, 0x...07), the mstatus/mie bit indices and the FSM state encoding.
REQ-037 Sub-module ysyx_040066_clint_timer holds the prescaler, mtime, mtimecmp and comparator; the top holds the bus, msip and FSM.

Verification
REQ-038 Reset, then read 0x4000 -> resp_rdata=0xFFFF_FFFF_FFFF_FFFF, err=0, mtip=0.
REQ-039 TICK_DIV=4, write mtimecmp=3 -> mtip rises 12 clks after release plus write latency. With MIE=1, MTIE=1: irq=1, irq_no=0x8000_0000_0000_0007, and irq holds until irq_ack, then 1 cycle low.
REQ-040 Write msip=1 while the timer is pending, with both enables set -> irq_no=0x8000_0000_0000_0003. Clear MSIE before ack -> irq drops to IDLE, then re-requests with code 0x...07.
REQ-041 Write mtime=0xFFFF_FFFF_FFFF_FFFF with wmask=0xFF, TICK_DIV=1 -> next read 0x0000_0000_0000_0000 (wrap). Write wmask=0x01 data 0x55 at an increment edge -> low byte 0x55, upper bytes incremented.
REQ-042 Read 0x0004 and 0x1000 -> resp_err=1, rdata=0. Hold resp_ready=0 for 3 cycles -> req_ready=0 and the response stays stable.
REQ-043 Drive rst=0 while resp_valid=1 and irq=1 -> next cycle resp_valid=0, irq=0, mtimecmp=all ones.

Source files
------------

// File: rtl/ysyx_040066_clint_pkg.sv
// Shared constants for the CLINT: register offsets, interrupt cause codes,
// CSR bit positions, interrupt FSM encoding and a byte-merge helper.
package ysyx_040066_clint_pkg;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    localparam logic [63:0] CAUSE_MSI = 64'h8000_0000_0000_0003;
    localparam logic [63:0] CAUSE_MTI = 64'h8000_0000_0000_0007;

    localparam int MSTATUS_MIE_BIT = 3;
    localparam int MIE_MSIE_BIT    = 3;
    localparam int MIE_MTIE_BIT    = 7;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_REQ   = 2'd1,
        IRQ_ACKED = 2'd2
    } irq_state_t;

    // Replace the bytes of base selected by wmask with the matching bytes of wdata.
    function automatic logic [63:0] merge_bytes(input logic [63:0] base,
                                                input logic [63:0] wdata,
                                                input logic [7:0]  wmask);
        logic [63:0] r;
        r = base;
        for (int i = 0; i < 8; i++) begin
            if (wmask[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ysyx_040066_clint_if.sv
// Request/response bus between a core-side master and the CLINT.
// Handshake: a request moves when req_valid && req_ready, a response is consumed
// when resp_valid && resp_ready; a valid holds its payload stable until it moves.
interface ysyx_040066_clint_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_040066_clint_timer.sv
// Prescaled 64-bit mtime counter, mtimecmp register and the unsigned
// compare that produces the raw timer-pending bit.
module ysyx_040066_clint_timer
    import ysyx_040066_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtime_wen,
    input  logic        mtimecmp_wen,
    input  logic [63:0] wdata,
    input  logic [7:0]  wmask,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        mtip
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc;
    logic        tick;
    logic [63:0] mtime_inc;

    assign tick      = (presc == PRESC_LAST);
    assign mtime_inc = mtime + {63'd0, tick};

    // A software write to mtime merges over the already-incremented value so a
    // coinciding tick is not lost on unwritten bytes, and restarts the prescaler.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc    <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
        end else begin
            if (mtime_wen) begin
                presc <= '0;
                mtime <= merge_bytes(mtime_inc, wdata, wmask);
            end else begin
                presc <= tick ? 16'd0 : presc + 16'd1;
                mtime <= mtime_inc;
            end
            if (mtimecmp_wen) mtimecmp <= merge_bytes(mtimecmp, wdata, wmask);
        end
    end

    assign mtip = (mtime >= mtimecmp);

endmodule

// File: rtl/ysyx_040066_clint.sv
// CLINT top: bus decode with a single outstanding transaction, msip register,
// and the interrupt request FSM that presents irq/irq_no to the core.
module ysyx_040066_clint
    import ysyx_040066_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_040066_clint_if.slave        bus,
    input  logic [63:0]               mstatus,
    input  logic [63:0]               mie,
    output logic                      irq,
    output logic [63:0]               irq_no,
    input  logic                      irq_ack,
    output logic                      mtip,
    output logic                      msip,
    output irq_state_t                fsm_state
);

    logic        sel_msip, sel_cmp, sel_mtime, addr_err, accept;
    logic        resp_valid_q, resp_err_q;
    logic [63:0] resp_rdata_q, rd_val;
    logic        msip_q;
    logic [63:0] mtime, mtimecmp;
    logic        en_s, en_t, cause_live;
    irq_state_t  state_q, state_d;
    logic [63:0] irq_no_q, irq_no_d;
    logic        irq_q;
    logic        unused_bits;

    // Offsets are 8-byte aligned, so any misaligned address simply fails to match.
    assign sel_msip  = (bus.req_addr == MSIP_OFF);
    assign sel_cmp   = (bus.req_addr == MTIMECMP_OFF);
    assign sel_mtime = (bus.req_addr == MTIME_OFF);
    assign addr_err  = !(sel_msip || sel_cmp || sel_mtime);
    assign accept    = bus.req_valid && !resp_valid_q;

    always_comb begin
        rd_val = '0;
        if (sel_msip)       rd_val = {63'd0, msip_q};
        else if (sel_cmp)   rd_val = mtimecmp;
        else if (sel_mtime) rd_val = mtime;
    end

    ysyx_040066_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .mtime_wen    (accept && bus.req_wen && sel_mtime),
        .mtimecmp_wen (accept && bus.req_wen && sel_cmp),
        .wdata        (bus.req_wdata),
        .wmask        (bus.req_wmask),
        .mtime        (mtime),
        .mtimecmp     (mtimecmp),
        .mtip         (mtip)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            msip_q       <= 1'b0;
        end else begin
            if (accept) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= (bus.req_wen || addr_err) ? 64'd0 : rd_val;
                resp_err_q   <= addr_err;
            end else if (resp_valid_q && bus.resp_ready) begin
                resp_valid_q <= 1'b0;
            end
            if (accept && bus.req_wen && sel_msip && bus.req_wmask[0]) begin
                msip_q <= bus.req_wdata[0];
            end
        end
    end

    assign bus.req_ready  = !resp_valid_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign msip           = msip_q;

    assign en_s = mstatus[MSTATUS_MIE_BIT] && mie[MIE_MSIE_BIT] && msip_q;
    assign en_t = mstatus[MSTATUS_MIE_BIT] && mie[MIE_MTIE_BIT] && mtip;
    // A pending request is withdrawn only when the source it advertises goes away.
    assign cause_live = (irq_no_q == CAUSE_MSI) ? en_s : en_t;

    always_comb begin
        state_d  = state_q;
        irq_no_d = irq_no_q;
        case (state_q)
            IRQ_IDLE: begin
                if (en_s || en_t) begin
                    state_d  = IRQ_REQ;
                    irq_no_d = en_s ? CAUSE_MSI : CAUSE_MTI;
                end
            end
            IRQ_REQ: begin
                if (irq_ack)          state_d = IRQ_ACKED;
                else if (!cause_live) state_d = IRQ_IDLE;
            end
            IRQ_ACKED: state_d = IRQ_IDLE;
            default:   state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IRQ_IDLE;
            irq_no_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            irq_no_q <= irq_no_d;
            irq_q    <= (state_d == IRQ_REQ);
        end
    end

    assign irq       = irq_q;
    assign irq_no    = irq_no_q;
    assign fsm_state = state_q;

    assign unused_bits = ^{mstatus[63:4], mstatus[2:0], mie[63:8], mie[6:4], mie[2:0]};

endmodule

// File: tb/tb_ysyx_040066_clint.sv
// Directed bench for the CLINT: one instance with TICK_DIV=4 for timer/irq
// scenarios and one with TICK_DIV=1 for mtime wrap and write/increment merging.
module tb_ysyx_040066_clint;
    import ysyx_040066_clint_pkg::*;

    localparam logic [63:0] ALL1     = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIE_ON   = 64'h8;
    localparam logic [63:0] MSIE_ON  = 64'h8;
    localparam logic [63:0] MTIE_ON  = 64'h80;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_040066_clint_if b4();
    ysyx_040066_clint_if b1();

    logic [63:0] mstatus4, mie4, mstatus1, mie1, irq_no4, irq_no1;
    logic        ack4, ack1, irq4, irq1, mtip4, mtip1, msip4, msip1;
    irq_state_t  st4, st1;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_040066_clint #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .bus(b4), .mstatus(mstatus4), .mie(mie4),
        .irq(irq4), .irq_no(irq_no4), .irq_ack(ack4), .mtip(mtip4), .msip(msip4),
        .fsm_state(st4)
    );

    ysyx_040066_clint #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .mstatus(mstatus1), .mie(mie1),
        .irq(irq1), .irq_no(irq_no1), .irq_ack(ack1), .mtip(mtip1), .msip(msip1),
        .fsm_state(st1)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer4(input logic wen, input logic [15:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, output logic [63:0] rdata, output logic err);
        int n;
        b4.req_valid = 1'b1; b4.req_wen = wen; b4.req_addr = addr;
        b4.req_wdata = wdata; b4.req_wmask = wmask; b4.resp_ready = 1'b1;
        n = 0;
        while (b4.req_ready !== 1'b1 && n < 16) begin step(1); n++; end
        step(1);
        b4.req_valid = 1'b0;
        while (b4.resp_valid !== 1'b1 && n < 16) begin step(1); n++; end
        if (n >= 16) begin n_checks++; n_fail++; $display("FAIL xfer4_timeout addr=%h", addr); end
        rdata = b4.resp_rdata; err = b4.resp_err;
        step(1);
    endtask

    task automatic xfer1(input logic wen, input logic [15:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, output logic [63:0] rdata, output logic err);
        int n;
        b1.req_valid = 1'b1; b1.req_wen = wen; b1.req_addr = addr;
        b1.req_wdata = wdata; b1.req_wmask = wmask; b1.resp_ready = 1'b1;
        n = 0;
        while (b1.req_ready !== 1'b1 && n < 16) begin step(1); n++; end
        step(1);
        b1.req_valid = 1'b0;
        while (b1.resp_valid !== 1'b1 && n < 16) begin step(1); n++; end
        if (n >= 16) begin n_checks++; n_fail++; $display("FAIL xfer1_timeout addr=%h", addr); end
        rdata = b1.resp_rdata; err = b1.resp_err;
        step(1);
    endtask

    task automatic test_reset();
        logic [63:0] rd; logic er;
        rst = 1'b0;
        step(3);
        n_checks++; if (b4.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", b4.resp_valid); end
        n_checks++; if (b4.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b exp 1", b4.req_ready); end
        n_checks++; if (b4.resp_rdata !== 64'd0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", b4.resp_rdata); end
        n_checks++; if (irq4 !== 1'b0 || irq_no4 !== 64'd0) begin n_fail++; $display("FAIL rst_irq got %b/%h exp 0/0", irq4, irq_no4); end
        n_checks++; if (st4 !== IRQ_IDLE) begin n_fail++; $display("FAIL rst_state got %0d exp %0d", st4, IRQ_IDLE); end
        n_checks++; if (msip4 !== 1'b0 || mtip4 !== 1'b0) begin n_fail++; $display("FAIL rst_pending got msip=%b mtip=%b exp 0/0", msip4, mtip4); end
        rst = 1'b1;
        xfer4(1'b0, MTIMECMP_OFF, 64'd0, 8'h00, rd, er);
        n_checks++; if (rd !== ALL1) begin n_fail++; $display("FAIL rst_mtimecmp got %h exp %h", rd, ALL1); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rst_mtimecmp_err got %b exp 0", er); end
        n_checks++; if (mtip4 !== 1'b0) begin n_fail++; $display("FAIL rst_mtip got %b exp 0", mtip4); end
    endtask

    task automatic test_timer_irq();
        logic [63:0] rd; logic er;
        mstatus4 = MIE_ON; mie4 = MTIE_ON;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        // first active edge after release accepts this write; mtime reaches 3 at edge 12
        xfer4(1'b1, MTIMECMP_OFF, 64'd3, 8'hFF, rd, er);
        n_checks++; if (er !== 1'b0 || rd !== 64'd0) begin n_fail++; $display("FAIL cmp_write_resp got err=%b rd=%h exp 0/0", er, rd); end
        step(9);
        n_checks++; if (mtip4 !== 1'b0) begin n_fail++; $display("FAIL mtip_edge11 got %b exp 0", mtip4); end
        step(1);
        n_checks++; if (mtip4 !== 1'b1) begin n_fail++; $display("FAIL mtip_edge12 got %b exp 1", mtip4); end
        n_checks++; if (irq4 !== 1'b0) begin n_fail++; $display("FAIL irq_edge12 got %b exp 0", irq4); end
        step(1);
        n_checks++; if (irq4 !== 1'b1) begin n_fail++; $display("FAIL irq_raise got %b exp 1", irq4); end
        n_checks++; if (irq_no4 !== CAUSE_MTI) begin n_fail++; $display("FAIL irq_no_mti got %h exp %h", irq_no4, CAUSE_MTI); end
        n_checks++; if (st4 !== IRQ_REQ) begin n_fail++; $display("FAIL state_req got %0d exp %0d", st4, IRQ_REQ); end
        step(3);
        n_checks++; if (irq4 !== 1'b1 || irq_no4 !== CAUSE_MTI) begin n_fail++; $display("FAIL irq_hold got %b/%h exp 1/%h", irq4, irq_no4, CAUSE_MTI); end
        ack4 = 1'b1;
        step(1);
        ack4 = 1'b0;
        n_checks++; if (irq4 !== 1'b0 || st4 !== IRQ_ACKED) begin n_fail++; $display("FAIL ack_low got irq=%b st=%0d exp 0/%0d", irq4, st4, IRQ_ACKED); end
        step(1);
        n_checks++; if (irq4 !== 1'b0 || st4 !== IRQ_IDLE) begin n_fail++; $display("FAIL ack_idle got irq=%b st=%0d exp 0/%0d", irq4, st4, IRQ_IDLE); end
        step(1);
        n_checks++; if (irq4 !== 1'b1) begin n_fail++; $display("FAIL rereq got %b exp 1", irq4); end
        mie4 = 64'd0;
        step(1);
        n_checks++; if (irq4 !== 1'b0 || st4 !== IRQ_IDLE) begin n_fail++; $display("FAIL withdraw got irq=%b st=%0d exp 0/%0d", irq4, st4, IRQ_IDLE); end
    endtask

    task automatic test_sw_priority();
        logic [63:0] rd; logic er;
        mstatus4 = 64'd0; mie4 = MSIE_ON | MTIE_ON;
        xfer4(1'b1, MSIP_OFF, 64'd1, 8'h01, rd, er);
        n_checks++; if (msip4 !== 1'b1) begin n_fail++; $display("FAIL msip_set got %b exp 1", msip4); end
        n_checks++; if (irq4 !== 1'b0) begin n_fail++; $display("FAIL irq_masked got %b exp 0", irq4); end
        mstatus4 = MIE_ON;
        step(1);
        n_checks++; if (irq4 !== 1'b1 || irq_no4 !== CAUSE_MSI) begin n_fail++; $display("FAIL sw_priority got %b/%h exp 1/%h", irq4, irq_no4, CAUSE_MSI); end
        mie4 = MTIE_ON;
        step(1);
        n_checks++; if (irq4 !== 1'b0 || st4 !== IRQ_IDLE) begin n_fail++; $display("FAIL sw_withdraw got irq=%b st=%0d exp 0/%0d", irq4, st4, IRQ_IDLE); end
        step(1);
        n_checks++; if (irq4 !== 1'b1 || irq_no4 !== CAUSE_MTI) begin n_fail++; $display("FAIL timer_rereq got %b/%h exp 1/%h", irq4, irq_no4, CAUSE_MTI); end
        mstatus4 = 64'd0;
        step(1);
        xfer4(1'b1, MSIP_OFF, 64'd0, 8'h01, rd, er);
        n_checks++; if (msip4 !== 1'b0 || irq4 !== 1'b0) begin n_fail++; $display("FAIL sw_cleanup got msip=%b irq=%b exp 0/0", msip4, irq4); end
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic er;
        xfer4(1'b0, 16'h0004, 64'd0, 8'h00, rd, er);
        n_checks++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL err_0004 got err=%b rd=%h exp 1/0", er, rd); end
        xfer4(1'b0, 16'h1000, 64'd0, 8'h00, rd, er);
        n_checks++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL err_1000 got err=%b rd=%h exp 1/0", er, rd); end
        xfer4(1'b1, 16'h4004, 64'd0, 8'hFF, rd, er);
        n_checks++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL err_wr4004 got err=%b rd=%h exp 1/0", er, rd); end
        xfer4(1'b0, MTIMECMP_OFF, 64'd0, 8'h00, rd, er);
        n_checks++; if (er !== 1'b0 || rd !== 64'd3) begin n_fail++; $display("FAIL cmp_unchanged got err=%b rd=%h exp 0/3", er, rd); end
        xfer4(1'b1, MSIP_OFF, ALL1, 8'hFF, rd, er);
        xfer4(1'b0, MSIP_OFF, 64'd0, 8'h00, rd, er);
        n_checks++; if (er !== 1'b0 || rd !== 64'd1) begin n_fail++; $display("FAIL msip_bit0_only got err=%b rd=%h exp 0/1", er, rd); end
        xfer4(1'b1, MSIP_OFF, 64'd0, 8'hFE, rd, er);
        n_checks++; if (msip4 !== 1'b1) begin n_fail++; $display("FAIL msip_wmask got %b exp 1", msip4); end
        xfer4(1'b1, MSIP_OFF, 64'd0, 8'h01, rd, er);
        n_checks++; if (msip4 !== 1'b0) begin n_fail++; $display("FAIL msip_clear got %b exp 0", msip4); end
    endtask

    task automatic test_backpressure();
        b4.resp_ready = 1'b0;
        b4.req_valid = 1'b1; b4.req_wen = 1'b0; b4.req_addr = MTIMECMP_OFF;
        step(1);
        b4.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (b4.resp_valid !== 1'b1 || b4.req_ready !== 1'b0 || b4.resp_rdata !== 64'd3 || b4.resp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d got v=%b rdy=%b rd=%h err=%b exp 1/0/3/0", i, b4.resp_valid, b4.req_ready, b4.resp_rdata, b4.resp_err);
            end
            step(1);
        end
        b4.resp_ready = 1'b1;
        step(1);
        n_checks++; if (b4.resp_valid !== 1'b0 || b4.req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release got v=%b rdy=%b exp 0/1", b4.resp_valid, b4.req_ready); end
    endtask

    task automatic test_wrap();
        logic [63:0] rd; logic er;
        xfer1(1'b1, MTIME_OFF, ALL1, 8'hFF, rd, er);
        xfer1(1'b0, MTIME_OFF, 64'd0, 8'h00, rd, er);
        n_checks++; if (rd !== 64'd0 || er !== 1'b0) begin n_fail++; $display("FAIL mtime_wrap got %h err=%b exp 0/0", rd, er); end
        // low byte carries into byte 1 on the same edge the 0x55 byte write lands
        xfer1(1'b1, MTIME_OFF, 64'h1122_3344_5566_77FE, 8'hFF, rd, er);
        xfer1(1'b1, MTIME_OFF, 64'h0000_0000_0000_0055, 8'h01, rd, er);
        xfer1(1'b0, MTIME_OFF, 64'd0, 8'h00, rd, er);
        n_checks++; if (rd !== 64'h1122_3344_5566_7856) begin n_fail++; $display("FAIL mtime_merge got %h exp %h", rd, 64'h1122_3344_5566_7856); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er;
        mstatus4 = MIE_ON; mie4 = MTIE_ON;
        step(1);
        b4.resp_ready = 1'b0;
        b4.req_valid = 1'b1; b4.req_wen = 1'b0; b4.req_addr = MTIMECMP_OFF;
        step(1);
        b4.req_valid = 1'b0;
        n_checks++; if (b4.resp_valid !== 1'b1 || irq4 !== 1'b1) begin n_fail++; $display("FAIL pre_reset got v=%b irq=%b exp 1/1", b4.resp_valid, irq4); end
        rst = 1'b0;
        step(1);
        n_checks++; if (b4.resp_valid !== 1'b0 || irq4 !== 1'b0 || irq_no4 !== 64'd0) begin n_fail++; $display("FAIL mid_reset got v=%b irq=%b no=%h exp 0/0/0", b4.resp_valid, irq4, irq_no4); end
        n_checks++; if (mtip4 !== 1'b0 || st4 !== IRQ_IDLE) begin n_fail++; $display("FAIL mid_reset_timer got mtip=%b st=%0d exp 0/%0d", mtip4, st4, IRQ_IDLE); end
        rst = 1'b1;
        xfer4(1'b0, MTIMECMP_OFF, 64'd0, 8'h00, rd, er);
        n_checks++; if (rd !== ALL1 || er !== 1'b0) begin n_fail++; $display("FAIL post_reset_cmp got %h err=%b exp %h/0", rd, er, ALL1); end
        n_checks++; if (irq4 !== 1'b0 || b4.resp_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_quiet got irq=%b v=%b exp 0/0", irq4, b4.resp_valid); end
    endtask

    initial begin
        b4.req_valid = 1'b0; b4.req_wen = 1'b0; b4.req_addr = '0; b4.req_wdata = '0;
        b4.req_wmask = '0; b4.resp_ready = 1'b1;
        b1.req_valid = 1'b0; b1.req_wen = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
        b1.req_wmask = '0; b1.resp_ready = 1'b1;
        mstatus4 = '0; mie4 = '0; ack4 = 1'b0;
        mstatus1 = '0; mie1 = '0; ack1 = 1'b0;
        test_reset();
        test_timer_irq();
        test_sw_priority();
        test_errors();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
